// File: rtl/rf_fifo_pkg.sv
// rf_fifo_pkg: shared types for the rf-backed valid/ready FIFO.
//   out_state_t : state of the 1-entry output stage in front of the rf read port.
//                 OUT_BYP is only reachable when RF_FIFO_BYPASS_EN is defined.
//   RF_FLOP_OUT : read-port style of the storage rf (1 = registered read data).
package rf_fifo_pkg;

  typedef enum logic [1:0] {
    OUT_EMPTY = 2'd0,
    OUT_RF    = 2'd1,
    OUT_BYP   = 2'd2
  } out_state_t;

  localparam int unsigned RF_FLOP_OUT = 1;

endpackage

// File: rtl/rf.sv
// rf: simple multi-port register file used as FIFO storage.
//   Parameters: W data width, N entries, FLOP_OUT (1 = read data registered on
//   i_ren and held while i_ren=0, 0 = combinational read), WR_N/RD_N port counts.
//   Ports:
//     i_clk                  clock
//     i_wen/i_wa/i_wdata     write ports (higher port index wins on same address)
//     i_ren/i_ra             read enables / addresses
//     o_rdata                read data per port
//   Contents are not reset.
module rf #(
  parameter int unsigned W        = 32,
  parameter int unsigned N        = 8,
  parameter int unsigned FLOP_OUT = 1,
  parameter int unsigned WR_N     = 1,
  parameter int unsigned RD_N     = 1,
  localparam int unsigned AW      = $clog2(N)
) (
  input  logic                       i_clk,
  input  logic [WR_N-1:0]            i_wen,
  input  logic [WR_N-1:0][AW-1:0]    i_wa,
  input  logic [WR_N-1:0][W-1:0]     i_wdata,
  input  logic [RD_N-1:0]            i_ren,
  input  logic [RD_N-1:0][AW-1:0]    i_ra,
  output logic [RD_N-1:0][W-1:0]     o_rdata
);

  logic [W-1:0] r_mem [N];

  always_ff @(posedge i_clk) begin
    for (int unsigned p = 0; p < WR_N; p++) begin
      if (i_wen[p]) r_mem[i_wa[p]] <= i_wdata[p];
    end
  end

  for (genvar g = 0; g < RD_N; g++) begin : g_rd
    if (FLOP_OUT != 0) begin : g_flop
      logic [W-1:0] r_q;
      always_ff @(posedge i_clk) begin
        if (i_ren[g]) r_q <= r_mem[i_ra[g]];
      end
      assign o_rdata[g] = r_q;
    end else begin : g_comb
      assign o_rdata[g] = r_mem[i_ra[g]];
    end
  end

endmodule

// File: rtl/rf_fifo_ptr.sv
// rf_fifo_ptr: $clog2(N)-bit pointer that advances on i_inc and wraps N-1 -> 0
//   explicitly, so N need not be a power of two.
//   Ports:
//     i_clk    clock
//     i_rst_n  asynchronous active-low reset (pointer -> 0)
//     i_inc    advance pointer this cycle
//     o_ptr    current pointer value
module rf_fifo_ptr #(
  parameter int unsigned N  = 8,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_inc,
  output logic [AW-1:0] o_ptr
);

  logic [AW-1:0] r_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == AW'(N - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/rf_fifo.sv
// rf_fifo: valid/ready FIFO built on an rf with registered read data.
//   A 1-entry output stage hides the rf read latency; capacity is N+1.
//   Optional feature macro: RF_FIFO_BYPASS_EN (push straight into a bypass
//   register when the FIFO is empty, 1-cycle latency instead of 2).
//   Ports:
//     clk                          clock, all state on posedge
//     rst                          asynchronous active-low reset
//     push_vld/push_data/push_rdy  producer side; fire = push_vld & push_rdy
//     pop_vld/pop_data/pop_rdy     consumer side; fire = pop_vld & pop_rdy
//     occupancy                    entries held (rf + output stage), 0..N+1
module rf_fifo
  import rf_fifo_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_data,
  output logic                   push_rdy,
  output logic                   pop_vld,
  output logic [W-1:0]           pop_data,
  input  logic                   pop_rdy,
  output logic [$clog2(N+2)-1:0] occupancy
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned OW = $clog2(N + 2);

  out_state_t    r_state;
  logic          r_pop_vld;
  logic [CW-1:0] r_rf_cnt;

  logic          w_push_fire;
  logic          w_pop_fire;
  logic          w_read_issue;
  logic          w_wen;
  logic          w_byp;
  logic [AW-1:0] w_wr_ptr;
  logic [AW-1:0] w_rd_ptr;
  logic [W-1:0]  w_rdata;

  // push_rdy looks only at registered rf_cnt: a same-cycle pop never frees a slot.
  assign push_rdy    = (r_rf_cnt != CW'(N));
  assign w_push_fire = push_vld & push_rdy;
  assign w_pop_fire  = r_pop_vld & pop_rdy;
  // Registered rf_cnt means an entry written this cycle is never read this cycle.
  assign w_read_issue = (r_rf_cnt != '0) && ((r_state == OUT_EMPTY) || w_pop_fire);

`ifdef RF_FIFO_BYPASS_EN
  logic [W-1:0] r_byp;

  assign w_byp = w_push_fire && (r_rf_cnt == '0) &&
                 ((r_state == OUT_EMPTY) || w_pop_fire) && !w_read_issue;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byp <= '0;
    end else if (w_byp) begin
      r_byp <= push_data;
    end
  end

  assign pop_data = (r_state == OUT_BYP) ? r_byp : w_rdata;
`else
  assign w_byp    = 1'b0;
  assign pop_data = w_rdata;
`endif

  assign w_wen = w_push_fire & ~w_byp;

  rf_fifo_ptr #(.N(N)) u_wr_ptr (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (w_wen),
    .o_ptr   (w_wr_ptr)
  );

  rf_fifo_ptr #(.N(N)) u_rd_ptr (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (w_read_issue),
    .o_ptr   (w_rd_ptr)
  );

  rf #(
    .W        (W),
    .N        (N),
    .FLOP_OUT (RF_FLOP_OUT),
    .WR_N     (1),
    .RD_N     (1)
  ) u_rf (
    .i_clk   (clk),
    .i_wen   (w_wen),
    .i_wa    (w_wr_ptr),
    .i_wdata (push_data),
    .i_ren   (w_read_issue),
    .i_ra    (w_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_cnt <= '0;
    end else begin
      r_rf_cnt <= r_rf_cnt + CW'(w_wen) - CW'(w_read_issue);
    end
  end

  // Output stage FSM; pop_vld is registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= OUT_EMPTY;
      r_pop_vld <= 1'b0;
    end else begin
      case (r_state)
        OUT_EMPTY: begin
          if (w_read_issue) begin
            r_state   <= OUT_RF;
            r_pop_vld <= 1'b1;
          end else if (w_byp) begin
            r_state   <= OUT_BYP;
            r_pop_vld <= 1'b1;
          end
        end
        default: begin
          if (w_pop_fire) begin
            if (w_read_issue) begin
              r_state   <= OUT_RF;
              r_pop_vld <= 1'b1;
            end else if (w_byp) begin
              r_state   <= OUT_BYP;
              r_pop_vld <= 1'b1;
            end else begin
              r_state   <= OUT_EMPTY;
              r_pop_vld <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign pop_vld   = r_pop_vld;
  assign occupancy = OW'(r_rf_cnt) + OW'(r_pop_vld);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(w_push_fire && (r_rf_cnt == CW'(N))))
        else $error("rf_fifo: push fired with rf full");
      assert (!(w_read_issue && (r_rf_cnt == '0)))
        else $error("rf_fifo: read issued with rf empty");
    end
  end
`endif

endmodule

// File: tb/tb_rf_fifo.sv
module tb_rf_fifo;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // N=8 instance
  logic         a_push_vld, a_push_rdy, a_pop_vld, a_pop_rdy;
  logic [W-1:0] a_push_data, a_pop_data;
  logic [3:0]   a_occ;

  // N=5 instance
  logic         b_push_vld, b_push_rdy, b_pop_vld, b_pop_rdy;
  logic [W-1:0] b_push_data, b_pop_data;
  logic [2:0]   b_occ;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rf_fifo #(.W(W), .N(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .push_vld  (a_push_vld),
    .push_data (a_push_data),
    .push_rdy  (a_push_rdy),
    .pop_vld   (a_pop_vld),
    .pop_data  (a_pop_data),
    .pop_rdy   (a_pop_rdy),
    .occupancy (a_occ)
  );

  rf_fifo #(.W(W), .N(5)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .push_vld  (b_push_vld),
    .push_data (b_push_data),
    .push_rdy  (b_push_rdy),
    .pop_vld   (b_pop_vld),
    .pop_data  (b_pop_data),
    .pop_rdy   (b_pop_rdy),
    .occupancy (b_occ)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] pdata;
    logic         pf, of;

    a_push_vld = 0; a_push_data = '0; a_pop_rdy = 0;
    b_push_vld = 0; b_push_data = '0; b_pop_rdy = 0;

    // 1: reset
    rst = 0;
    repeat (3) step();
    chk("rst_push_rdy", a_push_rdy, 1);
    chk("rst_pop_vld",  a_pop_vld, 0);
    chk("rst_occ",      a_occ, 0);
    chk("rst_occ5",     b_occ, 0);
    rst = 1;
    repeat (2) step();
    chk("idle_push_rdy", a_push_rdy, 1);
    chk("idle_pop_vld",  a_pop_vld, 0);
    chk("idle_occ",      a_occ, 0);

    // 2: fill to N+1 with pop blocked, then drain in order
    for (int i = 0; i < 9; i++) begin
      a_push_vld = 1; a_push_data = W'(i);
      chk($sformatf("fill_rdy_%0d", i), a_push_rdy, 1);
      step();
    end
    a_push_data = 32'h9;
    chk("full_push_rdy", a_push_rdy, 0);
    chk("full_occ", a_occ, 9);
    step();
    chk("full_hold_rdy", a_push_rdy, 0);
    chk("full_hold_occ", a_occ, 9);
    a_push_vld = 0; a_pop_rdy = 1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("drain_vld_%0d", i), a_pop_vld, 1);
      chk($sformatf("drain_data_%0d", i), a_pop_data, 64'(i));
      step();
    end
    chk("drain_end_vld", a_pop_vld, 0);
    chk("drain_end_occ", a_occ, 0);
    a_pop_rdy = 0;

    // 3: latency from empty
    a_push_vld = 1; a_push_data = 32'hA5;
    step();
    a_push_vld = 0;
`ifdef RF_FIFO_BYPASS_EN
    chk("lat_vld_c1", a_pop_vld, 1);
    chk("lat_data", a_pop_data, 64'hA5);
`else
    chk("lat_vld_c1", a_pop_vld, 0);
    step();
    chk("lat_vld_c2", a_pop_vld, 1);
    chk("lat_data", a_pop_data, 64'hA5);
`endif
    a_pop_rdy = 1;
    step();
    chk("lat_after_pop_vld", a_pop_vld, 0);
    a_pop_rdy = 0;

    // 5: full FIFO, push and pop in the same cycle
    for (int i = 0; i < 9; i++) begin
      a_push_vld = 1; a_push_data = 32'h20 + W'(i);
      step();
    end
    a_push_data = 32'h29;
    chk("fp_occ", a_occ, 9);
    a_pop_rdy = 1;
    chk("fp_push_rdy", a_push_rdy, 0);
    chk("fp_pop_data", a_pop_data, 64'h20);
    step();
    a_pop_rdy = 0;
    chk("fp_next_rdy", a_push_rdy, 1);
    chk("fp_next_occ", a_occ, 8);
    step();
    a_push_vld = 0;
    chk("fp_accept_occ", a_occ, 9);
    chk("fp_accept_rdy", a_push_rdy, 0);
    a_pop_rdy = 1;
    for (int i = 1; i < 10; i++) begin
      chk($sformatf("fp_drain_%0d", i), a_pop_data, 64'(32'h20 + i));
      step();
    end
    chk("fp_drain_end_vld", a_pop_vld, 0);
    a_pop_rdy = 0;

    // 6: reset mid-stream
    for (int i = 0; i < 4; i++) begin
      a_push_vld = 1; a_push_data = 32'h10 + W'(i);
      step();
    end
    a_push_vld = 0;
    chk("mid_occ4", a_occ, 4);
    #2;
    rst = 0;
    #1;
    chk("mid_rst_vld", a_pop_vld, 0);
    chk("mid_rst_occ", a_occ, 0);
    chk("mid_rst_rdy", a_push_rdy, 1);
    @(posedge clk);
    #1;
    rst = 1;
    a_push_vld = 1; a_push_data = 32'h77; a_pop_rdy = 1;
    step();
    a_push_vld = 0;
    for (int k = 0; k < 5; k++) begin
      if (a_pop_vld) break;
      step();
    end
    chk("mid_next_vld", a_pop_vld, 1);
    chk("mid_next_data", a_pop_data, 64'h77);
    step();
    chk("mid_after_vld", a_pop_vld, 0);
    a_pop_rdy = 0;

    // 4: random push/pop on N=5 against a scoreboard
    for (int c = 0; c < 50; c++) begin
      b_push_vld  = 1'($urandom_range(0, 1));
      b_pop_rdy   = 1'($urandom_range(0, 1));
      b_push_data = $urandom;
      chk($sformatf("wrap_occ_%0d", c), 64'(b_occ), 64'(q.size()));
      if (b_pop_vld && q.size() != 0)
        chk($sformatf("wrap_data_%0d", c), b_pop_data, q[0]);
      pf = b_push_vld & b_push_rdy;
      of = b_pop_vld & b_pop_rdy;
      pdata = b_push_data;
      step();
      if (of && q.size() != 0) void'(q.pop_front());
      if (pf) q.push_back(pdata);
    end
    b_push_vld = 0; b_pop_rdy = 1;
    for (int c = 0; c < 20; c++) begin
      if (q.size() == 0 && !b_pop_vld) break;
      chk($sformatf("wrapd_occ_%0d", c), 64'(b_occ), 64'(q.size()));
      if (b_pop_vld && q.size() != 0)
        chk($sformatf("wrapd_data_%0d", c), b_pop_data, q[0]);
      of = b_pop_vld;
      step();
      if (of && q.size() != 0) void'(q.pop_front());
    end
    chk("wrap_end_occ", 64'(b_occ), 64'(q.size()));
    chk("wrap_end_vld", b_pop_vld, 0);
    b_pop_rdy = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
